reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/foxtrot_pkg.sv | 21 ++
 rtl/rob_ptr.sv | 26 ++
 rtl/reorder_buffer.sv | 132 +++++++++++++
 tb/tb_reorder_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/foxtrot_pkg.sv
// Shared reorder-buffer types: entry-state struct and pointer-width constants.
package foxtrot_pkg;

  localparam int ROB_MAX_OPS  = 3;
  localparam int ROB_ARN_BITS = 6;
  localparam int ROB_PRN_BITS = 6;
  localparam int ROB_ID_BITS  = 6;
  localparam int ROB_DEPTH    = 2 ** ROB_ID_BITS;
  localparam int ROB_PTR_BITS = ROB_ID_BITS + 1;

  // Entry field widths follow the package constants; the top's parameters default to them.
  typedef struct packed {
    logic                                       reserved;
    logic                                       recorded;
    logic                                       done;
    logic [ROB_MAX_OPS-1:0]                     map_valid;
    logic [ROB_MAX_OPS-1:0][ROB_PRN_BITS-1:0]   map_prn;
    logic [ROB_MAX_OPS-1:0][ROB_ARN_BITS-1:0]   map_arn;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer: W index bits plus one wrap bit on top.
module rob_ptr #(
  parameter int W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  output logic [W:0] ptr_o
);

  logic [W:0] ptr_q, ptr_d;

  // Natural W+1-bit overflow toggles the wrap bit when the index passes DEPTH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + {{W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: reserve at tail, record old mappings, mark done, retire one per cycle at head.
// Optional ROB_COMMIT_STATS_EN adds commit_count and full_stall_count outputs.
module reorder_buffer import foxtrot_pkg::*; #(
  parameter int MAX_OPERANDS = ROB_MAX_OPS,
  parameter int ARN_BITS     = ROB_ARN_BITS,
  parameter int PRN_BITS     = ROB_PRN_BITS,
  parameter int INST_ID_BITS = ROB_ID_BITS,
  parameter int FU_COUNT     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   alloc_valid,
  output logic [INST_ID_BITS-1:0]                new_inst_id,
  output logic                                   rob_full,
  input  logic                                   rec_valid,
  input  logic [INST_ID_BITS-1:0]                rec_inst_id,
  input  logic [MAX_OPERANDS-1:0]                rec_map_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  rec_map_prn,
  input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  rec_map_arn,
  input  logic [FU_COUNT-1:0]                    complete_valid,
  input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]  complete_inst_id,
  output logic                                   commit_valid,
  output logic [INST_ID_BITS-1:0]                commit_inst_id,
  output logic [MAX_OPERANDS-1:0]                free_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns
`ifdef ROB_COMMIT_STATS_EN
  ,
  output logic [31:0]                            commit_count,
  output logic [31:0]                            full_stall_count
`endif
);

  localparam int DEPTH = 2 ** INST_ID_BITS;

  logic [INST_ID_BITS:0]   head_ptr, tail_ptr;
  logic [INST_ID_BITS-1:0] head_idx, tail_idx;
  logic                    alloc_fire, commit_fire;
  rob_entry_t              ent_q [DEPTH];
  rob_entry_t              head_ent;

  rob_ptr #(.W(INST_ID_BITS)) u_head (.clk(clk), .rst(rst), .inc_i(commit_fire), .ptr_o(head_ptr));
  rob_ptr #(.W(INST_ID_BITS)) u_tail (.clk(clk), .rst(rst), .inc_i(alloc_fire),  .ptr_o(tail_ptr));

  assign head_idx    = head_ptr[INST_ID_BITS-1:0];
  assign tail_idx    = tail_ptr[INST_ID_BITS-1:0];
  assign new_inst_id = tail_idx;
  assign rob_full    = (head_idx == tail_idx) && (head_ptr[INST_ID_BITS] != tail_ptr[INST_ID_BITS]);
  assign alloc_fire  = alloc_valid && !rob_full;

  // Retirement looks only at registered entry state, so same-cycle rec/complete waits an edge.
  assign head_ent    = ent_q[head_idx];
  assign commit_fire = head_ent.reserved && head_ent.recorded && head_ent.done;

  logic unused_arn;
  assign unused_arn = ^head_ent.map_arn;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (rec_valid && ent_q[rec_inst_id].reserved) begin
        ent_q[rec_inst_id].recorded  <= 1'b1;
        ent_q[rec_inst_id].map_valid <= rec_map_valid;
        ent_q[rec_inst_id].map_prn   <= rec_map_prn;
        ent_q[rec_inst_id].map_arn   <= rec_map_arn;
      end
      for (int k = 0; k < FU_COUNT; k++)
        if (complete_valid[k] && ent_q[complete_inst_id[k]].reserved)
          ent_q[complete_inst_id[k]].done <= 1'b1;
      // Head and tail never coincide on a live commit plus an accepted alloc.
      if (commit_fire) ent_q[head_idx] <= '0;
      if (alloc_fire) begin
        ent_q[tail_idx]          <= '0;
        ent_q[tail_idx].reserved <= 1'b1;
      end
    end
  end

  logic                                  commit_valid_q, commit_valid_d;
  logic [INST_ID_BITS-1:0]               commit_id_q, commit_id_d;
  logic [MAX_OPERANDS-1:0]               free_valid_q, free_valid_d;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] free_prns_q, free_prns_d;

  always_comb begin
    commit_valid_d = commit_fire;
    commit_id_d    = commit_id_q;
    free_valid_d   = '0;
    free_prns_d    = free_prns_q;
    if (commit_fire) begin
      commit_id_d  = head_idx;
      free_valid_d = head_ent.map_valid;
      free_prns_d  = head_ent.map_prn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      free_valid_q   <= '0;
      free_prns_q    <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      free_valid_q   <= free_valid_d;
      free_prns_q    <= free_prns_d;
    end
  end

  assign commit_valid   = commit_valid_q;
  assign commit_inst_id = commit_id_q;
  assign free_valid     = free_valid_q;
  assign free_prns      = free_prns_q;

`ifdef ROB_COMMIT_STATS_EN
  logic [31:0] commit_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      if (commit_fire)            commit_count_q <= commit_count_q + 32'd1;
      if (alloc_valid && rob_full) stall_count_q  <= stall_count_q + 32'd1;
    end
  end

  assign commit_count     = commit_count_q;
  assign full_stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic against a queue model.
module tb_reorder_buffer;

  localparam int OPS = 3, PRN = 6, ARN = 6, IDB = 6, FU = 4, DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, alloc_valid, rob_full, rec_valid, commit_valid;
  logic [IDB-1:0]           new_inst_id, rec_inst_id, commit_inst_id;
  logic [OPS-1:0]           rec_map_valid, free_valid;
  logic [OPS-1:0][PRN-1:0]  rec_map_prn, free_prns;
  logic [OPS-1:0][ARN-1:0]  rec_map_arn;
  logic [FU-1:0]            complete_valid;
  logic [FU-1:0][IDB-1:0]   complete_inst_id;
`ifdef ROB_COMMIT_STATS_EN
  logic [31:0]              commit_count, full_stall_count;
`endif

  reorder_buffer dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .new_inst_id(new_inst_id), .rob_full(rob_full),
    .rec_valid(rec_valid), .rec_inst_id(rec_inst_id), .rec_map_valid(rec_map_valid),
    .rec_map_prn(rec_map_prn), .rec_map_arn(rec_map_arn),
    .complete_valid(complete_valid), .complete_inst_id(complete_inst_id),
    .commit_valid(commit_valid), .commit_inst_id(commit_inst_id),
    .free_valid(free_valid), .free_prns(free_prns)
`ifdef ROB_COMMIT_STATS_EN
    , .commit_count(commit_count), .full_stall_count(full_stall_count)
`endif
  );

  int total = 0, bad = 0;

  // Reference model: program-order queue of live IDs plus per-ID status flags.
  int                      q[$];
  bit                      m_res[DEPTH], m_rec[DEPTH], m_done[DEPTH];
  logic [OPS-1:0]          m_mv[DEPTH];
  logic [OPS-1:0][PRN-1:0] m_mp[DEPTH];
  int                      m_tail;
  bit                      exp_cv;
  int                      exp_cid;
  logic [OPS-1:0]          exp_fv;
  logic [OPS-1:0][PRN-1:0] exp_fp;
  int                      exp_commits, exp_stalls;

  task automatic step(input bit r, input bit a, input bit rv, input int rid,
                      input logic [OPS-1:0] mv, input logic [OPS-1:0][PRN-1:0] mp,
                      input logic [FU-1:0] cv, input logic [FU-1:0][IDB-1:0] cid);
    bit pre_res[DEPTH];
    bit pre_full, com;
    int h;
    rst = r; alloc_valid = a; rec_valid = rv; rec_inst_id = rid[IDB-1:0];
    rec_map_valid = mv; rec_map_prn = mp; rec_map_arn = (OPS*ARN)'($urandom);
    complete_valid = cv; complete_inst_id = cid;
    @(posedge clk);
    if (r) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) begin m_res[i] = 0; m_rec[i] = 0; m_done[i] = 0; end
      m_tail = 0; exp_cv = 0; exp_cid = 0; exp_fv = '0; exp_fp = '0;
      exp_commits = 0; exp_stalls = 0;
    end else begin
      pre_full = (q.size() == DEPTH);
      pre_res  = m_res;
      com      = (q.size() > 0) && m_rec[q[0]] && m_done[q[0]];
      exp_cv   = com;
      exp_fv   = '0;
      h        = 0;
      if (com) begin h = q[0]; exp_cid = h; exp_fv = m_mv[h]; exp_fp = m_mp[h]; end
      if (rv && pre_res[rid]) begin m_rec[rid] = 1; m_mv[rid] = mv; m_mp[rid] = mp; end
      for (int k = 0; k < FU; k++) if (cv[k] && pre_res[cid[k]]) m_done[cid[k]] = 1;
      if (com) begin
        void'(q.pop_front());
        m_res[h] = 0; m_rec[h] = 0; m_done[h] = 0;
        exp_commits++;
      end
      if (a && !pre_full) begin
        m_res[m_tail] = 1; m_rec[m_tail] = 0; m_done[m_tail] = 0;
        q.push_back(m_tail);
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (a && pre_full) exp_stalls++;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, '0, '0, '0, '0);
    step(1, 1, 0, 0, '0, '0, '0, '0);
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_cv got=%0b want=0", commit_valid); end
    total++; if (commit_inst_id !== '0) begin bad++; $display("FAIL reset_cid got=%0d want=0", commit_inst_id); end
    total++; if (free_valid !== '0 || free_prns !== '0) begin bad++; $display("FAIL reset_free got=%b/%h want=0/0", free_valid, free_prns); end
    total++; if (new_inst_id !== '0 || rob_full !== 1'b0) begin bad++; $display("FAIL reset_ptr got id=%0d full=%0b want 0/0", new_inst_id, rob_full); end
  endtask

  task automatic test_alloc_id();
    step(1, 0, 0, 0, '0, '0, '0, '0);
    total++; if (new_inst_id !== 6'd0) begin bad++; $display("FAIL alloc_id0 got=%0d want=0", new_inst_id); end
    step(0, 1, 0, 0, '0, '0, '0, '0);
    total++; if (new_inst_id !== 6'd1 || rob_full !== 1'b0) begin bad++; $display("FAIL alloc_id1 got id=%0d full=%0b want 1/0", new_inst_id, rob_full); end
  endtask

  task automatic test_single_commit();
    logic [OPS-1:0][PRN-1:0] mp;
    logic [FU-1:0][IDB-1:0]  ci;
    mp = '0; mp[0] = 6'd5; ci = '0;
    step(1, 0, 0, 0, '0, '0, '0, '0);
    step(0, 1, 0, 0, '0, '0, '0, '0);
    step(0, 0, 1, 0, 3'b001, mp, '0, '0);
    step(0, 0, 0, 0, '0, '0, 4'b0001, ci);
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL single_early got cv=%0b want=0", commit_valid); end
    idle();
    total++; if (commit_valid !== 1'b1 || commit_inst_id !== 6'd0) begin bad++; $display("FAIL single_commit got cv=%0b id=%0d want 1/0", commit_valid, commit_inst_id); end
    total++; if (free_valid !== 3'b001 || free_prns[0] !== 6'd5) begin bad++; $display("FAIL single_free got fv=%b prn0=%0d want 001/5", free_valid, free_prns[0]); end
    idle();
    total++; if (commit_valid !== 1'b0 || free_valid !== '0) begin bad++; $display("FAIL single_pulse got cv=%0b fv=%b want 0/000", commit_valid, free_valid); end
  endtask

  task automatic test_in_order();
    logic [FU-1:0][IDB-1:0] ci;
    ci = '0;
    step(1, 0, 0, 0, '0, '0, '0, '0);
    step(0, 1, 0, 0, '0, '0, '0, '0);
    step(0, 1, 0, 0, '0, '0, '0, '0);
    step(0, 0, 1, 0, 3'b010, {6'd0, 6'd7, 6'd0}, '0, '0);
    step(0, 0, 1, 1, 3'b100, {6'd9, 6'd0, 6'd0}, '0, '0);
    ci[2] = 6'd1;
    step(0, 0, 0, 0, '0, '0, 4'b0100, ci);
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL order_hold got cv=%0b want=0", commit_valid); end
    ci = '0;
    step(0, 0, 0, 0, '0, '0, 4'b0001, ci);
    idle();
    total++; if (commit_valid !== 1'b1 || commit_inst_id !== 6'd0 || free_prns[1] !== 6'd7) begin bad++; $display("FAIL order_first got cv=%0b id=%0d prn1=%0d want 1/0/7", commit_valid, commit_inst_id, free_prns[1]); end
    idle();
    total++; if (commit_valid !== 1'b1 || commit_inst_id !== 6'd1 || free_valid !== 3'b100 || free_prns[2] !== 6'd9) begin bad++; $display("FAIL order_second got cv=%0b id=%0d fv=%b want 1/1/100", commit_valid, commit_inst_id, free_valid); end
  endtask

  task automatic test_full_wrap();
    logic [FU-1:0][IDB-1:0] ci;
    ci = '0;
    step(1, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, '0, '0, '0, '0);
    total++; if (rob_full !== 1'b1 || new_inst_id !== 6'd0) begin bad++; $display("FAIL full_set got full=%0b id=%0d want 1/0", rob_full, new_inst_id); end
    step(0, 1, 0, 0, '0, '0, '0, '0);
    total++; if (rob_full !== 1'b1 || new_inst_id !== 6'd0) begin bad++; $display("FAIL full_ignore got full=%0b id=%0d want 1/0", rob_full, new_inst_id); end
    step(0, 1, 1, 0, 3'b011, {6'd0, 6'd2, 6'd3}, 4'b1000, ci);
    step(0, 1, 0, 0, '0, '0, '0, '0);
    total++; if (commit_valid !== 1'b1 || commit_inst_id !== 6'd0 || rob_full !== 1'b0 || new_inst_id !== 6'd0) begin bad++; $display("FAIL full_commit got cv=%0b id=%0d full=%0b tail=%0d want 1/0/0/0", commit_valid, commit_inst_id, rob_full, new_inst_id); end
    step(0, 1, 0, 0, '0, '0, '0, '0);
    total++; if (rob_full !== 1'b1 || new_inst_id !== 6'd1) begin bad++; $display("FAIL full_wrap got full=%0b id=%0d want 1/1", rob_full, new_inst_id); end
  endtask

  task automatic test_four_fu();
    logic [FU-1:0][IDB-1:0] ci;
    step(1, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, i, 3'b111, {6'(i), 6'(i + 8), 6'(i + 16)}, '0, '0);
    ci = {6'd3, 6'd2, 6'd1, 6'd0};
    step(0, 0, 0, 0, '0, '0, 4'b1111, ci);
    for (int i = 0; i < 4; i++) begin
      idle();
      total++; if (commit_valid !== 1'b1 || commit_inst_id !== 6'(i) || free_prns[0] !== 6'(i + 16)) begin bad++; $display("FAIL fu4_commit%0d got cv=%0b id=%0d prn0=%0d", i, commit_valid, commit_inst_id, free_prns[0]); end
    end
    idle();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL fu4_end got cv=%0b want=0", commit_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [FU-1:0][IDB-1:0] ci;
    bit seen;
    step(1, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, i, 3'b111, {6'd1, 6'd2, 6'd3}, '0, '0);
    ci = {6'd3, 6'd2, 6'd1, 6'd0};
    step(0, 0, 0, 0, '0, '0, 4'b1111, ci);
    step(1, 0, 0, 0, '0, '0, '0, '0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (commit_valid !== 1'b0 || free_valid !== '0) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL midrst_free got a commit/free pulse want none"); end
    total++; if (new_inst_id !== 6'd0 || rob_full !== 1'b0) begin bad++; $display("FAIL midrst_ptr got id=%0d full=%0b want 0/0", new_inst_id, rob_full); end
  endtask

  function automatic int pick_id();
    if (q.size() > 0 && $urandom_range(0, 9) < 8) return q[$urandom_range(0, q.size() - 1)];
    return int'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic test_random();
    logic [FU-1:0]           cv;
    logic [FU-1:0][IDB-1:0]  ci;
    logic [OPS-1:0][PRN-1:0] mp;
    bit a, rv, pbad;
    int ap, cp;
    step(1, 0, 0, 0, '0, '0, '0, '0);
    for (int c = 0; c < 3000; c++) begin
      ap = ((c / 300) % 2 == 0) ? 90 : 40;
      cp = ((c / 300) % 2 == 0) ? 10 : 45;
      a  = ($urandom_range(0, 99) < ap);
      rv = ($urandom_range(0, 99) < 60);
      for (int k = 0; k < FU; k++) begin
        cv[k] = ($urandom_range(0, 99) < cp);
        ci[k] = 6'(pick_id());
      end
      mp = (OPS*PRN)'($urandom);
      step(0, a, rv, pick_id(), 3'($urandom), mp, cv, ci);
      pbad = 0;
      for (int i = 0; i < OPS; i++) if (exp_fv[i] && free_prns[i] !== exp_fp[i]) pbad = 1;
      total++; if (commit_valid !== exp_cv || (exp_cv && commit_inst_id !== 6'(exp_cid))) begin bad++; $display("FAIL rand_commit cyc=%0d got cv=%0b id=%0d want %0b/%0d", c, commit_valid, commit_inst_id, exp_cv, exp_cid); end
      total++; if (free_valid !== exp_fv || pbad) begin bad++; $display("FAIL rand_free cyc=%0d got fv=%b prns=%h want fv=%b prns=%h", c, free_valid, free_prns, exp_fv, exp_fp); end
      total++; if (rob_full !== (q.size() == DEPTH) || new_inst_id !== 6'(m_tail)) begin bad++; $display("FAIL rand_ptr cyc=%0d got full=%0b id=%0d want %0b/%0d", c, rob_full, new_inst_id, (q.size() == DEPTH), m_tail); end
    end
`ifdef ROB_COMMIT_STATS_EN
    total++; if (commit_count !== 32'(exp_commits) || full_stall_count !== 32'(exp_stalls)) begin bad++; $display("FAIL stats got %0d/%0d want %0d/%0d", commit_count, full_stall_count, exp_commits, exp_stalls); end
`endif
  endtask

  initial begin
    test_reset();
    test_alloc_id();
    test_single_commit();
    test_in_order();
    test_full_wrap();
    test_four_fu();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
